// File: rtl/exp_shift_gen.sv
// exp_shift_gen -- two-stage 2^x approximation by shifting, with a saturating
// pass-through for the gemm/div/log modes.
//   S1: decode the accumulator into exponent k, mantissa m and range flags.
//   S2: shift the mantissa (exp mode) or clip the raw value (other modes).
// Optional feature macro: EXP_SHIFT_ROUND_EN -- round half-up on exp-mode
// right shifts instead of truncating.
module exp_shift_gen #(
  parameter int INT_BW = 5,
  parameter int FRA_BW = 10,
  parameter int MUL_BW = 16,
  parameter int ACC_BW = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               gemm_uno,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [ACC_BW-1:0] acc_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [MUL_BW-1:0] y_o,
  output logic                     sat_o
);

  // Mantissa width: implicit leading one plus the fraction bits.
  localparam int M_W  = FRA_BW + 1;
  // Width of the full integer part of the accumulator.
  localparam int KF_W = ACC_BW - FRA_BW;
  // Width of the clamped exponent; holds MUL_BW and -(FRA_BW+2).
  localparam int K_W  = $clog2(MUL_BW + FRA_BW + 3) + 1;
  // Number of accumulator MSBs that must all agree for a value to fit MUL_BW.
  localparam int HI_W = ACC_BW - MUL_BW + 1;

  localparam int K_HI = MUL_BW - FRA_BW - 1;
  localparam int K_LO = -(FRA_BW + 2);

  localparam logic signed [KF_W-1:0] KF_MAX = KF_W'(MUL_BW);
  localparam logic signed [KF_W-1:0] KF_HI  = KF_W'(K_HI);
  localparam logic signed [KF_W-1:0] KF_LO  = KF_W'(K_LO);
  localparam logic signed [K_W-1:0]  KC_MAX = K_W'(MUL_BW);
  localparam logic signed [K_W-1:0]  KC_LO  = K_W'(K_LO);

  localparam logic [MUL_BW-1:0] Y_MAX = {1'b0, {(MUL_BW-1){1'b1}}};
  localparam logic [MUL_BW-1:0] Y_MIN = {1'b1, {(MUL_BW-1){1'b0}}};

  localparam logic [1:0] MODE_EXP = 2'b10;

  // The result format must be sign + integer + fraction bits.
  if (MUL_BW != INT_BW + FRA_BW + 1) begin : g_bad_cfg
    $error("exp_shift_gen: MUL_BW must equal INT_BW + FRA_BW + 1");
  end

  // Pass-through clip: {sat, y}.
  function automatic logic [MUL_BW:0] sat_pass(
    input logic [MUL_BW-1:0] raw,
    input logic              oor,
    input logic              neg
  );
    logic [MUL_BW:0] r;
    if (!oor)     r = {1'b0, raw};
    else if (neg) r = {1'b1, Y_MIN};
    else          r = {1'b1, Y_MAX};
    return r;
  endfunction

`ifdef EXP_SHIFT_ROUND_EN
  // Half-up rounding increment: the last bit shifted out by a right shift of sh.
  function automatic logic [MUL_BW-1:0] round_bit(
    input logic [MUL_BW-1:0] v,
    input logic [K_W-1:0]    sh
  );
    return (v >> (sh - K_W'(1))) & MUL_BW'(1);
  endfunction
`endif

  // Exp-mode result: {sat, y}; m scaled by 2^k, saturating above, zero far below.
  function automatic logic [MUL_BW:0] exp_shift(
    input logic [M_W-1:0]        m,
    input logic signed [K_W-1:0] k,
    input logic                  ovf
  );
    logic [MUL_BW-1:0] m_ext;
    logic [K_W-1:0]    rsh;
    logic [MUL_BW-1:0] y;
    logic [MUL_BW:0]   r;
    m_ext = MUL_BW'(m);
    rsh   = -k;
    y     = '0;
    if (ovf) begin
      r = {1'b1, Y_MAX};
    end else if (k <= KC_LO) begin
      r = '0;
    end else if (!k[K_W-1]) begin
      y = m_ext << k;
      r = {1'b0, y};
    end else begin
      y = m_ext >> rsh;
`ifdef EXP_SHIFT_ROUND_EN
      y = y + round_bit(m_ext, rsh);
`endif
      r = {1'b0, y};
    end
    return r;
  endfunction

  // Pipeline control
  logic vld_p1;
  logic vld_p2;
  logic s2_load;
  logic accept;

  assign s2_load  = ~vld_p2 | out_ready;
  assign in_ready = ~vld_p1 | s2_load;
  assign accept   = in_valid & in_ready;

  // S1 decode signals
  logic signed [KF_W-1:0] k_full;
  logic signed [K_W-1:0]  k_clamp;
  logic                   ovf_d;
  logic                   oor_d;

  // Split the accumulator into floor exponent and range flags.
  always_comb begin
    k_full = acc_i[ACC_BW-1:FRA_BW];
    if (k_full > KF_MAX)     k_clamp = KC_MAX;
    else if (k_full < KF_LO) k_clamp = KC_LO;
    else                     k_clamp = k_full[K_W-1:0];
    ovf_d = (k_full >= KF_HI);
    oor_d = ~((&acc_i[ACC_BW-1 -: HI_W]) | ~(|acc_i[ACC_BW-1 -: HI_W]));
  end

  // ---- stage 1 registers: decoded operands ----
  logic [1:0]              mode_p1;
  logic signed [K_W-1:0]   k_p1;
  logic                    ovf_p1;
  logic [M_W-1:0]          m_p1;
  logic [MUL_BW-1:0]       raw_p1;
  logic                    oor_p1;
  logic                    neg_p1;

  // Capture a decoded input whenever one is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      mode_p1 <= '0;
      k_p1    <= '0;
      ovf_p1  <= 1'b0;
      m_p1    <= '0;
      raw_p1  <= '0;
      oor_p1  <= 1'b0;
      neg_p1  <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (accept) begin
        mode_p1 <= gemm_uno;
        k_p1    <= k_clamp;
        ovf_p1  <= ovf_d;
        m_p1    <= {1'b1, acc_i[FRA_BW-1:0]};
        raw_p1  <= acc_i[MUL_BW-1:0];
        oor_p1  <= oor_d;
        neg_p1  <= acc_i[ACC_BW-1];
      end
    end
  end

  // S2 result selection
  logic [MUL_BW:0] res_d;

  // Choose the exp shift or the saturating pass-through by mode.
  always_comb begin
    if (mode_p1 == MODE_EXP) res_d = exp_shift(m_p1, k_p1, ovf_p1);
    else                     res_d = sat_pass(raw_p1, oor_p1, neg_p1);
  end

  // ---- stage 2 registers: output holding register ----
  logic signed [MUL_BW-1:0] y_p2;
  logic                     sat_p2;

  // Load the output register when it is empty or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      y_p2   <= '0;
      sat_p2 <= 1'b0;
    end else if (s2_load) begin
      vld_p2 <= vld_p1;
      if (vld_p1) {sat_p2, y_p2} <= res_d;
    end
  end

  assign out_valid = vld_p2;
  assign y_o       = y_p2;
  assign sat_o     = sat_p2;

endmodule

// File: tb/tb_exp_shift_gen.sv
// tb_exp_shift_gen -- directed bench for exp_shift_gen at default parameters.
module tb_exp_shift_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  gemm_uno = 2'b00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] acc_i = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] y_o;
  logic        sat_o;

  always #5 clk = ~clk;

  exp_shift_gen #(
    .INT_BW(5), .FRA_BW(10), .MUL_BW(16), .ACC_BW(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gemm_uno(gemm_uno), .in_valid(in_valid),
    .in_ready(in_ready), .acc_i(acc_i), .out_valid(out_valid),
    .out_ready(out_ready), .y_o(y_o), .sat_o(sat_o)
  );

`ifdef EXP_SHIFT_ROUND_EN
  localparam logic [15:0] Y_FC01 = 16'h0201;
  localparam logic [15:0] Y_K11  = 16'h0001;
`else
  localparam logic [15:0] Y_FC01 = 16'h0200;
  localparam logic [15:0] Y_K11  = 16'h0000;
`endif

  typedef struct {
    logic [15:0] y;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  bit          held_vld = 1'b0;
  logic [15:0] held_y = '0;
  logic        held_sat = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: checks every delivered result in order, plus hold under backpressure.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        check_eq("hold_valid", {31'b0, out_valid}, 32'd1);
        check_eq("hold_y", {16'b0, y_o}, {16'b0, held_y});
        check_eq("hold_sat", {31'b0, sat_o}, {31'b0, held_sat});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", {31'b0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("y", {16'b0, y_o}, {16'b0, e.y});
          check_eq("sat", {31'b0, sat_o}, {31'b0, e.sat});
          if (chk_lat) check_eq("latency", cyc - e.cyc, 32'd2);
        end
      end
      held_vld = out_valid && !out_ready;
      held_y   = y_o;
      held_sat = sat_o;
    end
  end

  // Present one input (entered #1 after a rising edge) and hold it until accepted.
  task automatic send(input logic [1:0] md, input logic [31:0] a,
                      input logic [15:0] ey, input logic es);
    bit   done = 1'b0;
    exp_t e;
    gemm_uno = md;
    acc_i    = a;
    in_valid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.y   = ey;
        e.sat = es;
        e.cyc = cyc;
        sb.push_back(e);
        done  = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check_eq("accept_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 40 && sb.size() > 0; t++) @(posedge clk);
    #1;
    check_eq("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_y", {16'b0, y_o}, 32'd0);
    check_eq("rst_sat", {31'b0, sat_o}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Exp mode, back-to-back with fixed latency
    chk_lat = 1'b1;
    send(2'b10, 32'h00000400, 16'h0800, 1'b0);
    send(2'b10, 32'h00000200, 16'h0600, 1'b0);
    send(2'b10, 32'hFFFFFC00, 16'h0200, 1'b0);
    send(2'b10, 32'h00005000, 16'h7FFF, 1'b1);
    send(2'b10, 32'hFFFFD000, 16'h0000, 1'b0);
    send(2'b10, 32'hFFFFFC01, Y_FC01,   1'b0);
    send(2'b10, 32'h000013FF, 16'h7FF0, 1'b0);
    send(2'b10, 32'h00001400, 16'h7FFF, 1'b1);
    send(2'b10, 32'hFFFFF800, 16'h0100, 1'b0);
    send(2'b10, 32'hFFFFD400, Y_K11,    1'b0);
    send(2'b10, 32'h000003FF, 16'h07FF, 1'b0);
    send(2'b10, 32'h80000000, 16'h0000, 1'b0);

    // Pass-through modes
    send(2'b00, 32'h00001234, 16'h1234, 1'b0);
    send(2'b00, 32'h00012345, 16'h7FFF, 1'b1);
    send(2'b00, 32'hFFFF7000, 16'h8000, 1'b1);
    send(2'b01, 32'h00007FFF, 16'h7FFF, 1'b0);
    send(2'b11, 32'hFFFF8000, 16'h8000, 1'b0);
    send(2'b11, 32'h00008000, 16'h7FFF, 1'b1);
    drain();

    // Backpressure: out_ready low for 3 cycles while 4 inputs stream
    chk_lat = 1'b0;
    fork
      begin
        send(2'b00, 32'h00000011, 16'h0011, 1'b0);
        send(2'b01, 32'h00007FFF, 16'h7FFF, 1'b0);
        send(2'b11, 32'hFFFF8000, 16'h8000, 1'b0);
        send(2'b10, 32'h000013FF, 16'h7FF0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("bp_out_valid", {31'b0, out_valid}, 32'd1);
        check_eq("bp_y_first", {16'b0, y_o}, 32'h0011);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two items in flight
    chk_lat = 1'b1;
    send(2'b00, 32'h00000055, 16'h0055, 1'b0);
    send(2'b00, 32'h00000066, 16'h0066, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("no_stale", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    send(2'b10, 32'h00000400, 16'h0800, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exp_shift_gen.md
EXP_SHIFT_GEN -- requirements
Module: exp_shift_gen

Interface
REQ-001 SHALL have parameter INT_BW, default 5, integer bits of the MUL_BW fixed-point result.
REQ-002 SHALL have parameter FRA_BW, default 10, fraction bits of both the accumulator and the result.
REQ-003 SHALL have parameter MUL_BW, default 16, result width (INT_BW+FRA_BW+1).
REQ-004 SHALL have parameter ACC_BW, default 32, accumulator input width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  clock, rising edge.
REQ-006 rst_n  in  1  asynchronous reset, active low.
REQ-007 gemm_uno  in  2  mode: 00 gemm, 01 div, 10 exp, 11 log; sampled with acc_i.
REQ-008 in_valid  in  1  acc_i/gemm_uno valid.
REQ-009 in_ready  out  1  block accepts input this cycle.
REQ-010 acc_i  in  ACC_BW  signed accumulator, Q(ACC_BW-FRA_BW).FRA_BW.
REQ-011 out_valid  out  1  y_o/sat_o valid.
REQ-012 out_ready  in  1  downstream accepts output.
REQ-013 y_o  out  MUL_BW  signed result, Q(INT_BW).FRA_BW.
REQ-014 sat_o  out  1  y_o was clipped.

Function
REQ-015 SHALL transfer input when in_valid&in_ready and output when out_valid&out_ready.
REQ-016 SHALL be a 2-stage pipeline (S1 decode, S2 shift/saturate); out_valid rises on the 2nd rising edge after acceptance; throughput 1/cycle with out_ready held high.
REQ-017 S2 SHALL load when ~s2_valid|out_ready; S1 SHALL advance when S2 loads; in_ready = ~s1_valid|S1 advances (combinational, no input-to-in_ready path other than out_ready).
REQ-018 y_o/sat_o SHALL stay stable while out_valid&~out_ready; no transfer SHALL be dropped or duplicated.
REQ-019 Exp mode (10): k = acc_i>>>FRA_BW (arithmetic, floor), f = acc_i[FRA_BW-1:0], mantissa m = 2^FRA_BW + f (FRA_BW+1 bits, 2^f ~ 1+f).
REQ-020 Exp mode: k>=0 SHALL give y = m<<k; k<0 SHALL give y = m>>(-k) truncated; result non-negative.
REQ-021 Exp mode: k >= MUL_BW-FRA_BW-1 (5 at defaults) SHALL give y_o=2^(MUL_BW-1)-1, sat_o=1; k <= -(FRA_BW+2) SHALL give y_o=0, sat_o=0.
REQ-022 Other modes SHALL pass acc_i through, saturated to signed MUL_BW range (max 0x7FFF, min 0x8000 at defaults), sat_o=1 when clipped.
REQ-023 S1 SHALL register mode, k clamped to [-(FRA_BW+2), MUL_BW] with overflow flag, m, and the raw low MUL_BW bits plus a range flag for pass-through.
REQ-024 Simultaneous input accept and output drain SHALL sustain 1 result/cycle with no bubble.

Reset
REQ-025 rst_n low SHALL asynchronously clear s1_valid, s2_valid, out_valid=0, y_o=0, sat_o=0 and all pipeline data registers.
REQ-026 Reset mid-operation SHALL discard all in-flight data; first accepted input after release produces out_valid two cycles later.
REQ-027 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-028 Macro EXP_SHIFT_ROUND_EN defined: exp-mode right shifts SHALL round half-up (add bit (-k-1) of m); k=-(FRA_BW+1) then yields y_o=1.
REQ-029 Macro EXP_SHIFT_ROUND_EN undefined: exp-mode right shifts SHALL truncate; rounding logic absent.

Verification (defaults INT_BW=5, FRA_BW=10, MUL_BW=16, ACC_BW=32)
REQ-030 Exp, out_ready=1: acc_i 0x00000400 -> y_o 0x0800; 0x00000200 -> 0x0600; 0xFFFFFC00 -> 0x0200; each out_valid 2 cycles after accept, back-to-back.
REQ-031 Exp: acc_i 0x00005000 -> y_o 0x7FFF, sat_o=1; acc_i 0xFFFFD000 (k=-12) -> y_o 0x0000, sat_o=0.
REQ-032 Exp: acc_i 0xFFFFFC01 -> y_o 0x0200 without EXP_SHIFT_ROUND_EN, 0x0201 with it.
REQ-033 Gemm: acc_i 0x00001234 -> 0x1234, sat_o=0; 0x00012345 -> 0x7FFF, sat_o=1; 0xFFFF7000 -> 0x8000, sat_o=1.
REQ-034 Backpressure: 4 inputs streamed, out_ready low 3 cycles -> in_ready low once both stages full, y_o held, all 4 results delivered in order.
REQ-035 rst_n pulsed low with 2 items in flight -> out_valid=0 immediately, no stale result after release.
